// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Purpose : Definitions shared by every mem_par user. It holds the fixed BRAM
//           read latency, the address/length width helpers and the read-stream
//           FSM state type.
// Contents: RD_LAT_BRAM  memory read latency, enB to doutB valid
//           addr_w()     address width for a given DEPTH
//           len_w()      word-count width for a given DEPTH; it can hold DEPTH
//           rd_state_e   read-stream FSM states
// ---------------------------------------------------------------------------
package mem_pkg;

    localparam int RD_LAT_BRAM = 1;

    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int len_w(input int depth);
        return addr_w(depth) + 1;
    endfunction

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } rd_state_e;

endpackage

// File: rtl/mem_rd_stream_if.sv
// ---------------------------------------------------------------------------
// mem_rd_stream_if
// Purpose : Valid/ready word stream that carries an end-of-command flag.
// Signals : valid  beat valid            (master -> slave)
//           data   beat data, WIDTH bits (master -> slave)
//           last   final beat of command (master -> slave)
//           ready  downstream accept     (slave -> master)
// ---------------------------------------------------------------------------
interface mem_rd_stream_if #(
    parameter int WIDTH = 32
);
    logic             valid;
    logic [WIDTH-1:0] data;
    logic             last;
    logic             ready;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/mem_rd_fifo.sv
// ---------------------------------------------------------------------------
// mem_rd_fifo
// Purpose : Small register FIFO that catches memory read data. Entry 0 is
//           always the head, so the output needs no read mux. The producer
//           must never push into a full FIFO unless it also pops in the same
//           cycle. The caller's credit logic enforces this.
// Ports   : clkB       clock
//           rst        synchronous active-high reset; empties the FIFO
//           push       write push_data this cycle
//           push_data  data to write
//           pop        drop the head entry this cycle (only when occ != 0)
//           head_data  current head entry (zero after reset)
//           occ        number of valid entries, 0..DEPTH_F
// ---------------------------------------------------------------------------
module mem_rd_fifo #(
    parameter int WIDTH   = 32,
    parameter int DEPTH_F = 2
) (
    input  logic                           clkB,
    input  logic                           rst,
    input  logic                           push,
    input  logic [WIDTH-1:0]               push_data,
    input  logic                           pop,
    output logic [WIDTH-1:0]               head_data,
    output logic [$clog2(DEPTH_F+1)-1:0]   occ
);
    localparam int OW = $clog2(DEPTH_F + 1);
    localparam int IW = (DEPTH_F > 1) ? $clog2(DEPTH_F) : 1;

    logic [WIDTH-1:0] entries [DEPTH_F];
    logic [IW-1:0]    wr_idx;

    // A pop shifts everything down by one. The push slot therefore moves with it.
    assign wr_idx    = pop ? IW'(occ - 1'b1) : IW'(occ);
    assign head_data = entries[0];

    // NOTE: the storage is only DEPTH_F flops, so it is cleared on reset with
    // the rest of the state. This keeps the stream data at zero after reset.
    // A large RAM array would normally be left unreset.
    always_ff @(posedge clkB) begin
        if (rst) begin
            occ <= '0;
            for (int i = 0; i < DEPTH_F; i++) begin
                entries[i] <= '0;
            end
        end else begin
            if (pop) begin
                for (int i = 0; i < DEPTH_F - 1; i++) begin
                    entries[i] <= entries[i+1];
                end
            end
            // This comes after the shift so that a push into the freed slot wins.
            if (push) begin
                entries[wr_idx] <= push_data;
            end
            occ <= occ + OW'(push) - OW'(pop);
        end
    end

endmodule

// File: rtl/mem_rd_stream.sv
// ---------------------------------------------------------------------------
// mem_rd_stream
// Purpose : Read-side streaming engine for mem_par port B. A start command
//           reads len words from base_addr upward, wrapping at DEPTH. The
//           words come out as a valid/ready stream with a last flag, at one
//           beat per cycle. Reads are only issued while the FIFO has room
//           for their data, so backpressure never loses a word.
// Ports   : clkB       clock, shared with mem_par port B
//           rst        synchronous active-high reset
//           start      command strobe, accepted only while busy == 0
//           base_addr  first word address (< DEPTH)
//           len        word count; 0 completes at once with no reads
//           busy       command in progress
//           done       one-cycle completion pulse
//           enB        mem_par read enable
//           addrB      mem_par read address; it only moves after an enB
//           doutB      mem_par read data, valid RD_LAT cycles after enB
//           m          output stream (master modport)
// ---------------------------------------------------------------------------
module mem_rd_stream
    import mem_pkg::*;
#(
    parameter  int WIDTH  = 32,
    parameter  int DEPTH  = 512,
    parameter  int RD_LAT = RD_LAT_BRAM,
    localparam int AW     = addr_w(DEPTH),
    localparam int LW     = len_w(DEPTH)
) (
    input  logic              clkB,
    input  logic              rst,
    input  logic              start,
    input  logic [AW-1:0]     base_addr,
    input  logic [LW-1:0]     len,
    output logic              busy,
    output logic              done,
    output logic              enB,
    output logic [AW-1:0]     addrB,
    input  logic [WIDTH-1:0]  doutB,
    mem_rd_stream_if.master   m
);
    // One entry covers each read in flight, plus one more for the beat on
    // the output. That is enough for back-to-back beats.
    localparam int FIFO_D = RD_LAT + 1;

    rd_state_e                      state, state_n;
    logic [LW-1:0]                  len_q;
    logic [AW-1:0]                  addr_q;
    logic [LW-1:0]                  issue_cnt;
    logic [LW-1:0]                  beat_cnt;
    logic [RD_LAT-1:0]              rd_pipe;   // bit i set: a read issued i+1 cycles ago
    logic                           done_q;
    logic                           done_n;

    logic                           accept;
    logic                           issue;
    logic                           pop;
    logic                           last_beat;
    int                             credit_used;
    logic [$clog2(FIFO_D+1)-1:0]    occ;
    logic [WIDTH-1:0]               head_data;

    // ------------------------------------------------------------------
    // Response FIFO. Data enters exactly RD_LAT cycles after its enB.
    // ------------------------------------------------------------------
    mem_rd_fifo #(
        .WIDTH   (WIDTH),
        .DEPTH_F (FIFO_D)
    ) u_fifo (
        .clkB      (clkB),
        .rst       (rst),
        .push      (rd_pipe[RD_LAT-1]),
        .push_data (doutB),
        .pop       (pop),
        .head_data (head_data),
        .occ       (occ)
    );

    assign m.valid   = (occ != '0);
    assign m.data    = head_data;
    assign pop       = m.valid & m.ready;
    assign last_beat = (beat_cnt == len_q - 1'b1);
    assign m.last    = m.valid & last_beat;

    assign accept    = (state == IDLE) && start && (len != '0);

    // ------------------------------------------------------------------
    // Credit check. Every issued read must eventually own a FIFO slot. The
    // sum counts slots already filled and reads still in flight. A pop
    // this cycle frees a slot in time for a new read.
    // ------------------------------------------------------------------
    always_comb begin
        credit_used = int'(occ) + $countones(rd_pipe) - int'(pop);
        issue       = (state == READ) && (credit_used < FIFO_D);
    end

    // ------------------------------------------------------------------
    // FSM next state and completion pulse
    // ------------------------------------------------------------------
    // NOTE: every output of this block gets a default before the case
    // statement. A path that forgets to assign one would otherwise infer a latch.
    always_comb begin
        state_n = state;
        done_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        state_n = READ;
                    end else begin
                        done_n = 1'b1;
                    end
                end
            end
            READ: begin
                if (issue && (issue_cnt == len_q - 1'b1)) begin
                    state_n = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && last_beat) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State, counters and the read-latency tracker
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only. Every
    // register then samples values from before the clock edge, whatever
    // order the statements are written in.
    always_ff @(posedge clkB) begin
        if (rst) begin
            state     <= IDLE;
            len_q     <= '0;
            addr_q    <= '0;
            issue_cnt <= '0;
            beat_cnt  <= '0;
            rd_pipe   <= '0;
            done_q    <= 1'b0;
        end else begin
            state   <= state_n;
            done_q  <= done_n;
            rd_pipe <= (rd_pipe << 1) | RD_LAT'(issue);

            if (accept) begin
                len_q     <= len;
                addr_q    <= base_addr;
                issue_cnt <= '0;
                beat_cnt  <= '0;
            end else begin
                if (issue) begin
                    // Compare and reset, because DEPTH need not be a power of two.
                    addr_q    <= (addr_q == AW'(DEPTH - 1)) ? '0 : addr_q + 1'b1;
                    issue_cnt <= issue_cnt + 1'b1;
                end
                if (pop) begin
                    beat_cnt <= beat_cnt + 1'b1;
                end
            end
        end
    end

    assign busy  = (state != IDLE);
    assign done  = done_q;
    assign enB   = issue;
    assign addrB = addr_q;

endmodule

// File: tb/tb_mem_rd_stream.sv
// ---------------------------------------------------------------------------
// tb_mem_rd_stream
// Two engines share one set of command inputs. Instance A has DEPTH=512 and
// mem[i]=i. Instance B has DEPTH=1000 and mem[i]=0xB0000000+i. The sel signal
// routes start to one engine and muxes its outputs into one view. The
// expected values come from the command alone: address (base+k) mod DEPTH and
// the matching word, with last on word len-1. Completion timing and the
// occupancy limit are derived from the counts of reads issued and beats accepted.
// ---------------------------------------------------------------------------
module tb_mem_rd_stream;

    localparam int DW = 32;

    logic        clkB = 1'b0;
    logic        rst;
    logic        start;
    logic        sel;
    logic        m_ready;
    logic [9:0]  base;
    logic [10:0] len;

    always #5 clkB = ~clkB;

    // ---------------- instance A: DEPTH 512 ----------------
    logic          busy_a, done_a, en_a;
    logic [8:0]    addr_a;
    logic [DW-1:0] dout_a;
    logic [DW-1:0] mem_a [512];
    mem_rd_stream_if #(.WIDTH(DW)) if_a ();
    assign if_a.ready = m_ready;

    mem_rd_stream #(.WIDTH(DW), .DEPTH(512), .RD_LAT(1)) dut_a (
        .clkB      (clkB),
        .rst       (rst),
        .start     (start & ~sel),
        .base_addr (base[8:0]),
        .len       (len[9:0]),
        .busy      (busy_a),
        .done      (done_a),
        .enB       (en_a),
        .addrB     (addr_a),
        .doutB     (dout_a),
        .m         (if_a)
    );
    always @(posedge clkB) if (en_a) dout_a <= mem_a[addr_a];

    // ---------------- instance B: DEPTH 1000 ----------------
    logic          busy_b, done_b, en_b;
    logic [9:0]    addr_b;
    logic [DW-1:0] dout_b;
    logic [DW-1:0] mem_b [1000];
    mem_rd_stream_if #(.WIDTH(DW)) if_b ();
    assign if_b.ready = m_ready;

    mem_rd_stream #(.WIDTH(DW), .DEPTH(1000), .RD_LAT(1)) dut_b (
        .clkB      (clkB),
        .rst       (rst),
        .start     (start & sel),
        .base_addr (base),
        .len       (len),
        .busy      (busy_b),
        .done      (done_b),
        .enB       (en_b),
        .addrB     (addr_b),
        .doutB     (dout_b),
        .m         (if_b)
    );
    always @(posedge clkB) if (en_b) dout_b <= mem_b[addr_b];

    // ---------------- muxed view of the selected engine ----------------
    logic          v_busy, v_done, v_en, v_valid, v_last;
    logic [9:0]    v_addr;
    logic [DW-1:0] v_data;
    assign v_busy  = sel ? busy_b      : busy_a;
    assign v_done  = sel ? done_b      : done_a;
    assign v_en    = sel ? en_b        : en_a;
    assign v_addr  = sel ? addr_b      : {1'b0, addr_a};
    assign v_valid = sel ? if_b.valid  : if_a.valid;
    assign v_data  = sel ? if_b.data   : if_a.data;
    assign v_last  = sel ? if_b.last   : if_a.last;

    int checks = 0;
    int errors = 0;

    // Timing of the most recent command, in cycles after the start cycle.
    int first_en, last_en, first_valid, last_hs;

    function automatic logic [DW-1:0] model_word(input logic s, input int a);
        return s ? mem_b[a] : mem_a[a];
    endfunction

    // Issues one command in the current cycle (cycle 0), then scores it
    // cycle by cycle until its done pulse. poke > 0 pulses a stray start
    // (base 100, len 2) in that cycle.
    task automatic run_cmd(input logic s, input int b, input int l,
                           input bit rand_ready, input int poke);
        int            exp_addr[$];
        logic [DW-1:0] exp_data[$];
        int            depth;
        int            n_iss, n_pop, k, end_cycle;
        bit            stall;
        logic [DW-1:0] held_data;
        logic          held_last;
        logic          exp_busy;
        depth = s ? 1000 : 512;
        n_iss = 0; n_pop = 0; k = 0; stall = 0;
        held_data = '0; held_last = 1'b0;
        end_cycle = (l == 0) ? 1 : -1;
        first_en = -1; last_en = -1; first_valid = -1; last_hs = -1;
        for (int i = 0; i < l; i++) begin
            exp_addr.push_back((b + i) % depth);
            exp_data.push_back(model_word(s, (b + i) % depth));
        end
        sel   = s;
        base  = 10'(b);
        len   = 11'(l);
        start = 1'b1;
        m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        while (1) begin
            @(negedge clkB);
            k++;
            start = (k == poke);
            if (k == poke) begin
                base = 10'd100;
                len  = 11'd2;
            end
            m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (v_en) begin
                checks++;
                if (n_iss >= l) begin
                    errors++;
                    $display("FAIL extra_enB: cycle %0d addrB %0d, required none (len %0d)", k, v_addr, l);
                end else if (int'(v_addr) != exp_addr[n_iss]) begin
                    errors++;
                    $display("FAIL addrB: read %0d got %0d required %0d", n_iss, v_addr, exp_addr[n_iss]);
                end
                if (first_en < 0) first_en = k;
                last_en = k;
                n_iss++;
            end
            if (stall) begin
                checks++;
                if (!v_valid || v_data !== held_data || v_last !== held_last) begin
                    errors++;
                    $display("FAIL stall_hold: got valid %0b data %08h last %0b required 1 %08h %0b",
                             v_valid, v_data, v_last, held_data, held_last);
                end
            end
            if (v_valid && first_valid < 0) first_valid = k;
            if (v_valid && m_ready) begin
                checks++;
                if (n_pop >= l) begin
                    errors++;
                    $display("FAIL extra_beat: cycle %0d data %08h, required none", k, v_data);
                end else if (v_data !== exp_data[n_pop] || v_last !== (n_pop == l - 1)) begin
                    errors++;
                    $display("FAIL beat: index %0d got %08h last %0b required %08h last %0b",
                             n_pop, v_data, v_last, exp_data[n_pop], (n_pop == l - 1));
                end
                n_pop++;
                if (n_pop == l) begin
                    last_hs   = k;
                    end_cycle = k + 1;
                end
            end
            stall     = v_valid && !m_ready;
            held_data = v_data;
            held_last = v_last;
            checks++;
            if (n_iss - n_pop > 2) begin
                errors++;
                $display("FAIL credit: outstanding %0d required <= 2", n_iss - n_pop);
            end
            exp_busy = (l != 0) && (last_hs < 0 || k <= last_hs);
            checks++;
            if (v_busy !== exp_busy) begin
                errors++;
                $display("FAIL busy: cycle %0d got %0b required %0b", k, v_busy, exp_busy);
            end
            checks++;
            if (v_done !== (k == end_cycle)) begin
                errors++;
                $display("FAIL done: cycle %0d got %0b required %0b", k, v_done, (k == end_cycle));
            end
            if (k == end_cycle) break;
            if (k > 6 * l + 40) begin
                errors++;
                $display("FAIL timeout: base %0d len %0d, beats %0d reads %0d", b, l, n_pop, n_iss);
                break;
            end
        end
        checks++;
        if (n_pop != l || n_iss != l) begin
            errors++;
            $display("FAIL count: beats %0d reads %0d required %0d each", n_pop, n_iss, l);
        end
        start = 1'b0;
    endtask

    // Checks that the selected engine stays quiet for n cycles.
    task automatic expect_idle(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clkB);
            #1;
            checks++;
            if (v_en || v_valid || v_done || v_busy) begin
                errors++;
                $display("FAIL %s: en %0b valid %0b done %0b busy %0b required all 0",
                         tag, v_en, v_valid, v_done, v_busy);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; sel = 1'b0; m_ready = 1'b1; base = '0; len = '0;
        repeat (3) @(negedge clkB);
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            #1;
            checks++;
            if ({v_busy, v_done, v_en, v_valid, v_last} !== 5'b0 || v_addr !== '0 || v_data !== '0) begin
                errors++;
                $display("FAIL reset_state: sel %0d busy %0b done %0b en %0b addr %0d valid %0b data %08h last %0b required all 0",
                         s, v_busy, v_done, v_en, v_addr, v_valid, v_data, v_last);
            end
        end
        sel = 1'b0;
        rst = 1'b0;
        expect_idle(2, "post_reset_idle");
    endtask

    task automatic test_basic();
        @(negedge clkB);
        run_cmd(1'b0, 0, 4, 1'b0, -1);
        checks++;
        if (first_en != 1 || last_en != 4 || first_valid != 3 || last_hs != 6) begin
            errors++;
            $display("FAIL basic_latency: en %0d-%0d first beat %0d last %0d required 1-4 3 6",
                     first_en, last_en, first_valid, last_hs);
        end
    endtask

    task automatic test_wrap();
        @(negedge clkB);
        run_cmd(1'b0, 510, 4, 1'b0, -1);
        run_cmd(1'b1, 998, 4, 1'b0, -1);
        checks++;
        if (last_hs != 6) begin
            errors++;
            $display("FAIL wrap_latency: last beat cycle %0d required 6", last_hs);
        end
        run_cmd(1'b0, 300, 600, 1'b1, -1);   // longer than DEPTH, so words are re-read
    endtask

    task automatic test_backpressure();
        @(negedge clkB);
        for (int i = 0; i < 4; i++) begin
            run_cmd(1'b0, int'($urandom_range(0, 511)), 16, 1'b1, -1);
        end
        for (int i = 0; i < 10; i++) begin
            logic s;
            s = 1'($urandom_range(0, 1));
            run_cmd(s, int'($urandom_range(0, s ? 999 : 511)), int'($urandom_range(1, 40)), 1'b1, -1);
        end
    endtask

    task automatic test_len_zero();
        @(negedge clkB);
        run_cmd(1'b0, 33, 0, 1'b0, -1);
        expect_idle(3, "len0_idle");
    endtask

    task automatic test_ignored_start();
        @(negedge clkB);
        run_cmd(1'b0, 40, 6, 1'b0, 2);
        run_cmd(1'b0, 300, 3, 1'b1, -1);     // issued in the done cycle
        expect_idle(5, "after_ignored_idle");
    endtask

    task automatic test_reset_mid();
        int beats;
        bit hit;
        beats = 0;
        hit   = 0;
        @(negedge clkB);
        sel = 1'b0; base = 10'd20; len = 11'd16; start = 1'b1; m_ready = 1'b1;
        for (int k = 0; k < 60 && !hit; k++) begin
            @(negedge clkB);
            start = 1'b0;
            #1;
            if (v_valid && m_ready) begin
                if (beats == 5) hit = 1;
                else beats++;
            end
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL reset_mid_reach: beats seen %0d required beat 5", beats);
        end
        rst = 1'b1;
        @(negedge clkB);
        #1;
        checks++;
        if ({v_busy, v_done, v_en, v_valid, v_last} !== 5'b0 || v_addr !== '0 || v_data !== '0) begin
            errors++;
            $display("FAIL reset_mid_state: busy %0b done %0b en %0b addr %0d valid %0b data %08h last %0b required all 0",
                     v_busy, v_done, v_en, v_addr, v_valid, v_data, v_last);
        end
        rst = 1'b0;
        expect_idle(4, "reset_mid_no_done");
        run_cmd(1'b0, 7, 1, 1'b0, -1);
    endtask

    initial begin
        for (int i = 0; i < 512; i++)  mem_a[i] = DW'(i);
        for (int i = 0; i < 1000; i++) mem_b[i] = 32'hB000_0000 | DW'(i);
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_len_zero();
        test_ignored_start();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
